// File: rtl/event_pulse_pacer_pkg.sv
// rtl/event_pulse_pacer_pkg.sv - shared state encoding for the event pulse pacer
package event_pulse_pacer_pkg;

    // PULSE is the single cycle pulse_out is high; GAP enforces the low time before the next pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pacerState_e;

endpackage

// File: rtl/sat_event_counter.sv
// rtl/sat_event_counter.sv - saturating up/down event counter with sticky overflow
module sat_event_counter
    import event_pulse_pacer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             incr,
    input  logic             decr,
    input  logic             clearOverflow,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;

    // An event with no matching issue while full has nowhere to go
    logic drop;
    assign drop = incr && !decr && (count == COUNT_MAX);

    // Simultaneous incr and decr cancel: the event is consumed directly; a drop wins over a clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (incr && !decr && !drop) begin
                count <= count + 1'b1;
            end else if (decr && !incr && (count != '0)) begin
                count <= count - 1'b1;
            end
            overflow <= drop | (overflow & ~clearOverflow);
        end
    end

endmodule

// File: rtl/event_pulse_pacer.sv
// rtl/event_pulse_pacer.sv - paces event strobes into pulses spaced for a pulse synchronizer
module event_pulse_pacer
    import event_pulse_pacer_pkg::*;
#(
    parameter int GAP_CYCLES = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 event_in,
    input  logic                 clear_overflow,
    output logic                 pulse_out,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 overflow,
    output logic                 idle
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    pacerState_e      state;
    logic [GAP_W-1:0] gapCnt;
    logic             slotOpen;
    logic             issue;

    // A pulse may start from IDLE or on the final GAP cycle, giving a period of GAP_CYCLES+1
    assign slotOpen = (state == IDLE) || ((state == GAP) && (gapCnt == '0));
    assign issue    = slotOpen && ((pending != '0) || event_in);

    // Pacing FSM; pulse_out is registered alongside the transition into PULSE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gapCnt    <= '0;
            pulse_out <= 1'b0;
        end else begin
            pulse_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state     <= PULSE;
                        pulse_out <= 1'b1;
                    end
                end
                PULSE: begin
                    state  <= GAP;
                    gapCnt <= GAP_LOAD;
                end
                GAP: begin
                    if (gapCnt != '0) begin
                        gapCnt <= gapCnt - 1'b1;
                    end else if (issue) begin
                        state     <= PULSE;
                        pulse_out <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gapCnt <= '0;
                end
            endcase
        end
    end

    sat_event_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_pendingCounter (
        .clk          (clk),
        .reset_n      (reset_n),
        .incr         (event_in),
        .decr         (issue),
        .clearOverflow(clear_overflow),
        .count        (pending),
        .overflow     (overflow)
    );

    assign idle = (state == IDLE) && (pending == '0);

endmodule

// File: tb/tb_event_pulse_pacer.sv
// tb/tb_event_pulse_pacer.sv - self-checking bench for event_pulse_pacer
module tb_event_pulse_pacer;

    localparam int GAP  = 8;
    localparam int CW   = 4;
    localparam int MAXP = (1 << CW) - 1;
    localparam int LOGN = 200;

    logic          clk;
    logic          reset_n;
    logic          event_in;
    logic          clear_overflow;
    logic          pulse_out;
    logic [CW-1:0] pending;
    logic          overflow;
    logic          idle;

    event_pulse_pacer #(
        .GAP_CYCLES(GAP),
        .CNT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .event_in      (event_in),
        .clear_overflow(clear_overflow),
        .pulse_out     (pulse_out),
        .pending       (pending),
        .overflow      (overflow),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Model: pending count, sticky overflow and the timestamp of the last issue
    int cyc;
    int mPend;
    int mOv;
    int mPulse;
    int lastIssue;

    int pulseLog [LOGN];
    int pendLog  [LOGN];
    int ovLog    [LOGN];
    int idleLog  [LOGN];

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic doReset();
        event_in       = 1'b0;
        clear_overflow = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        cyc       = 0;
        mPend     = 0;
        mOv       = 0;
        mPulse    = 0;
        lastIssue = -100;
        for (int i = 0; i < LOGN; i++) begin
            pulseLog[i] = 0;
            pendLog[i]  = 0;
            ovLog[i]    = 0;
            idleLog[i]  = 0;
        end
    endtask

    // Compare the current cycle's outputs, apply this cycle's inputs, advance the model one cycle
    task automatic runCycle(input logic ev, input logic clr);
        int expIdle;
        int canIssue;
        int issue;
        int drop;
        expIdle = ((cyc >= lastIssue + GAP + 2) && (mPend == 0)) ? 1 : 0;
        check("pulse_out", int'(pulse_out), mPulse);
        check("pending", int'(pending), mPend);
        check("overflow", int'(overflow), mOv);
        check("idle", int'(idle), expIdle);
        if (cyc < LOGN) begin
            pulseLog[cyc] = int'(pulse_out);
            pendLog[cyc]  = int'(pending);
            ovLog[cyc]    = int'(overflow);
            idleLog[cyc]  = int'(idle);
        end
        event_in       = ev;
        clear_overflow = clr;
        canIssue = (cyc >= lastIssue + GAP + 1) ? 1 : 0;
        issue    = (canIssue != 0 && (mPend > 0 || ev)) ? 1 : 0;
        drop     = (ev && issue == 0 && mPend == MAXP) ? 1 : 0;
        if (issue != 0 && !ev) mPend = mPend - 1;
        else if (ev && issue == 0 && drop == 0) mPend = mPend + 1;
        mOv    = (drop != 0 || (mOv != 0 && !clr)) ? 1 : 0;
        mPulse = issue;
        if (issue != 0) lastIssue = cyc;
        @(negedge clk);
        cyc++;
    endtask

    function automatic int countPulses(input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) n += pulseLog[i];
        return n;
    endfunction

    function automatic int maxPend(input int lo, input int hi);
        int m = 0;
        for (int i = lo; i <= hi; i++) if (pendLog[i] > m) m = pendLog[i];
        return m;
    endfunction

    initial begin
        // Single isolated event
        doReset();
        for (int c = 0; c < 14; c++) runCycle(c == 0, 1'b0);
        check("single_pulse_c1", pulseLog[1], 1);
        check("single_pulse_count", countPulses(0, 13), 1);
        check("single_idle_c9", idleLog[9], 0);
        check("single_idle_c10", idleLog[10], 1);

        // Three back-to-back events
        doReset();
        for (int c = 0; c < 25; c++) runCycle(c <= 2, 1'b0);
        check("burst3_p1", pulseLog[1], 1);
        check("burst3_p10", pulseLog[10], 1);
        check("burst3_p19", pulseLog[19], 1);
        check("burst3_count", countPulses(0, 24), 3);
        check("burst3_pend_after1", pendLog[2], 1);
        check("burst3_pend_after2", pendLog[3], 2);
        check("burst3_pend_after9", pendLog[10], 1);
        check("burst3_pend_after18", pendLog[19], 0);

        // Event held high into saturation, clear coinciding with a drop, then a lone clear
        doReset();
        for (int c = 0; c < 170; c++) runCycle(c <= 19, (c == 19) || (c == 20));
        check("sat_ov_before17", ovLog[17], 0);
        check("sat_ov_after17", ovLog[18], 1);
        check("sat_pend_after19", pendLog[20], 15);
        check("sat_clr_with_drop", ovLog[20], 1);
        check("sat_clr_alone", ovLog[21], 0);
        check("sat_pulse_count", countPulses(0, 169), 18);
        check("sat_pulse_154", pulseLog[154], 1);
        check("sat_pulse_145", pulseLog[145], 1);
        check("sat_no_pulse_163", pulseLog[163], 0);
        check("sat_drained", pendLog[169], 0);

        // Second event lands on the last GAP cycle
        doReset();
        for (int c = 0; c < 26; c++) runCycle((c == 0) || (c == 9), 1'b0);
        check("lastgap_p1", pulseLog[1], 1);
        check("lastgap_p10", pulseLog[10], 1);
        check("lastgap_count", countPulses(0, 25), 2);
        check("lastgap_pend_zero", maxPend(0, 25), 0);

        // Asynchronous reset with events pending during GAP
        doReset();
        for (int c = 0; c < 6; c++) runCycle(1'b1, 1'b0);
        check("areset_pend_before", int'(pending), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_pulse", int'(pulse_out), 0);
        check("areset_pend", int'(pending), 0);
        check("areset_ov", int'(overflow), 0);
        check("areset_idle", int'(idle), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        cyc       = 0;
        mPend     = 0;
        mOv       = 0;
        mPulse    = 0;
        lastIssue = -100;
        for (int i = 0; i < LOGN; i++) pulseLog[i] = 0;
        for (int c = 0; c < 30; c++) runCycle(1'b0, 1'b0);
        check("areset_no_pulses", countPulses(0, 29), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/event_pulse_pacer.md
EVENT_PULSE_PACER -- requirements
Module: event_pulse_pacer

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 8: minimum low cycles between output pulses; legal range >=1; set >= the downstream clock-crossing handshake round trip in clk cycles.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the pending-event counter.
REQ-003 SHALL have port clk  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port event_in  input  1  single-cycle event strobe; may be high on consecutive cycles.
REQ-006 SHALL have port clear_overflow  input  1  synchronous clear of the overflow flag.
REQ-007 SHALL have port pulse_out  output  1  registered one-cycle pulse, one per accepted event; feeds a pulse synchronizer input.
REQ-008 SHALL have port pending  output  CNT_WIDTH  accepted events not yet issued.
REQ-009 SHALL have port overflow  output  1  sticky flag: at least one event was lost.
REQ-010 SHALL have port idle  output  1  high when state is IDLE and pending==0.

Function
REQ-011 SHALL implement states IDLE, PULSE, GAP; pulse_out SHALL be 1 exactly while state==PULSE.
REQ-012 IDLE: if pending!=0 or event_in, SHALL go to PULSE next cycle (an issue); otherwise SHALL stay in IDLE.
REQ-013 PULSE SHALL last exactly one cycle, then go to GAP with gap_cnt loaded to GAP_CYCLES-1.
REQ-014 GAP: gap_cnt SHALL decrement each cycle; at gap_cnt==0, SHALL issue (go to PULSE) if pending!=0 or event_in, else go to IDLE.
REQ-015 Latency: event_in in cycle N with the block idle SHALL produce pulse_out high in cycle N+1 only.
REQ-016 Back-to-back issued pulses SHALL have period exactly GAP_CYCLES+1 cycles.
REQ-017 Counter update: pending_next = pending + event_in - issue; an event arriving in an issuing cycle SHALL be consumed directly.
REQ-018 pending SHALL saturate at 2^CNT_WIDTH-1; an event that would exceed it SHALL be dropped and SHALL set overflow.
REQ-019 overflow SHALL clear on clear_overflow; if a drop and clear_overflow coincide, overflow SHALL be 1.
REQ-020 pending SHALL never underflow; an issue with pending==0 requires event_in==1 in that cycle.

Reset
REQ-021 reset_n low SHALL immediately force state=IDLE, pulse_out=0, pending=0, gap_cnt=0, overflow=0, idle=1.
REQ-022 Reset asserted mid-operation SHALL discard all pending events; no pulse SHALL follow deassertion without a new event_in.
REQ-023 Reset deassertion is synchronised externally; the block SHALL need no internal reset synchroniser.

Structure
REQ-024 State encodings (IDLE, PULSE, GAP) SHALL be defined in the shared package; GAP_CYCLES and CNT_WIDTH SHALL be parameters, not package constants.
REQ-025 The saturating up/down pending counter with overflow detection SHALL be the one sub-module, sat_event_counter.
REQ-026 pulse_out, pending, overflow and idle SHALL be register outputs or decoded only from registers; no combinational path from inputs.

Verification (GAP_CYCLES=8, CNT_WIDTH=4, event cycle numbers relative to reset release)
REQ-027 Single event_in at cycle 0 -> pulse_out high cycle 1 only; idle=1 from cycle 10.
REQ-028 event_in cycles 0,1,2 -> pulse_out high at cycles 1,10,19 only; pending 1,2 at end of cycles 1,2, then 1 after cycle 9, 0 after cycle 18.
REQ-029 event_in held high cycles 0-19 -> overflow rises after the cycle-17 event; pending=15 after cycle 19; 2 events lost; exactly 18 pulses in total, at 1,10,19,...,154.
REQ-030 clear_overflow pulsed in the same cycle as a dropped event -> overflow remains 1; clear_overflow alone one cycle later -> overflow 0.
REQ-031 Event at cycle 0, second event at cycle 9 (last GAP cycle) -> pulses at cycles 1 and 10, pending stays 0 throughout.
REQ-032 pending=5 in GAP, reset_n pulled low asynchronously -> pulse_out=0, pending=0 and overflow=0 before the next clk edge; no pulses after release.
